// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and widths for the instruction-fetch stage
package fetch_stage_pkg;

    localparam int FS_ISIZE = 16;

    typedef enum logic [1:0] {
        FS_RUN  = 2'b00,
        FS_BUF  = 2'b01,
        FS_DROP = 2'b10
    } fs_state_t;

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry {valid, inst, pc} skid buffer for decode stalls
module fetch_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic         i_clear,
    input  logic [W-1:0] i_inst,
    input  logic [W-1:0] i_pc,
    output logic         o_valid,
    output logic [W-1:0] o_inst,
    output logic [W-1:0] o_pc
);

    logic         r_valid;
    logic [W-1:0] r_inst;
    logic [W-1:0] r_pc;

    // occupancy flag: clear/unload win over load so a squash can never leave a stale entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clear || i_unload) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // payload only moves on load; contents are ignored while r_valid is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= '0;
            r_pc   <= '0;
        end else if (i_load && !i_clear) begin
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, imem request handshake, skid buffer and IF/ID register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               ISIZE    = FS_ISIZE,
    parameter logic [ISIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_id,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             imem_req,
    output logic [ISIZE-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic [ISIZE-1:0] imem_rdata,
    output logic             if_id_valid,
    output logic [ISIZE-1:0] if_id_inst,
    output logic [ISIZE-1:0] if_id_pc,
    output logic [ISIZE-1:0] if_id_npc
);

    fs_state_t        r_state;
    fs_state_t        w_state_nxt;
    logic [ISIZE-1:0] r_pc;
    logic             r_req;
    logic [ISIZE-1:0] r_addr;
    logic             r_valid;
    logic [ISIZE-1:0] r_inst;
    logic [ISIZE-1:0] r_ipc;
    logic [ISIZE-1:0] r_npc;

    logic [ISIZE-1:0] w_pc_nxt;
    logic             w_req_nxt;
    logic [ISIZE-1:0] w_addr_nxt;
    logic             w_ifid_load;
    logic             w_ifid_kill;
    logic             w_ifid_from_skid;
    logic             w_skid_load;
    logic             w_skid_unload;
    logic             w_skid_clear;
    logic             w_skid_valid;
    logic [ISIZE-1:0] w_skid_inst;
    logic [ISIZE-1:0] w_skid_pc;
    logic [ISIZE-1:0] w_pc_inc;
    logic [ISIZE-1:0] w_ld_inst;
    logic [ISIZE-1:0] w_ld_pc;
    logic [ISIZE-1:0] w_ld_npc;

    // pc+1 wraps naturally modulo 2^ISIZE
    assign w_pc_inc  = r_pc + ISIZE'(1);
    assign w_ld_inst = w_ifid_from_skid ? w_skid_inst : imem_rdata;
    assign w_ld_pc   = w_ifid_from_skid ? w_skid_pc   : r_pc;
    assign w_ld_npc  = w_ld_pc + ISIZE'(1);

    fetch_skid #(.W(ISIZE)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_inst   (imem_rdata),
        .i_pc     (r_pc),
        .o_valid  (w_skid_valid),
        .o_inst   (w_skid_inst),
        .o_pc     (w_skid_pc)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FS_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state: a redirect with an uncancellable request in flight parks in DROP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FS_RUN: begin
                if (redirect_valid) begin
                    w_state_nxt = (r_req && !imem_ready) ? FS_DROP : FS_RUN;
                end else if (r_req && imem_ready && stall_id) begin
                    w_state_nxt = FS_BUF;
                end
            end
            FS_BUF: begin
                if (redirect_valid || !stall_id) begin
                    w_state_nxt = FS_RUN;
                end
            end
            FS_DROP: begin
                if (imem_ready) begin
                    w_state_nxt = FS_RUN;
                end
            end
            default: w_state_nxt = FS_RUN;
        endcase
    end

    // datapath controls: pc, next request, IF/ID load/flush and skid moves
    always_comb begin
        w_pc_nxt         = r_pc;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_ifid_load      = 1'b0;
        w_ifid_kill      = 1'b0;
        w_ifid_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_unload    = 1'b0;
        w_skid_clear     = 1'b0;
        case (r_state)
            FS_RUN: begin
                if (redirect_valid) begin
                    w_ifid_kill  = 1'b1;
                    w_skid_clear = 1'b1;
                    w_pc_nxt     = redirect_pc;
                    if (!(r_req && !imem_ready)) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = redirect_pc;
                    end
                end else if (!r_req) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_ifid_kill = !stall_id;
                end else if (imem_ready) begin
                    w_pc_nxt = w_pc_inc;
                    if (!stall_id) begin
                        w_ifid_load = 1'b1;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = w_pc_inc;
                    end else begin
                        w_skid_load = 1'b1;
                        w_req_nxt   = 1'b0;
                    end
                end else begin
                    w_ifid_kill = !stall_id;
                end
            end
            FS_BUF: begin
                if (redirect_valid) begin
                    w_ifid_kill  = 1'b1;
                    w_skid_clear = 1'b1;
                    w_pc_nxt     = redirect_pc;
                    w_req_nxt    = 1'b1;
                    w_addr_nxt   = redirect_pc;
                end else if (!stall_id) begin
                    w_ifid_load      = w_skid_valid;
                    w_ifid_from_skid = 1'b1;
                    w_skid_unload    = 1'b1;
                    w_req_nxt        = 1'b1;
                    w_addr_nxt       = r_pc;
                end
            end
            FS_DROP: begin
                w_ifid_kill = 1'b1;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
                if (imem_ready) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = redirect_valid ? redirect_pc : r_pc;
                end
            end
            default: begin
                w_ifid_kill = 1'b1;
            end
        endcase
    end

    // PC and request registers; imem_addr only changes when a new request starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_req  <= 1'b0;
            r_addr <= RESET_PC;
        end else begin
            r_pc   <= w_pc_nxt;
            r_req  <= w_req_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    // IF/ID register: load, flush to bubble, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_ipc   <= '0;
            r_npc   <= '0;
        end else if (w_ifid_load) begin
            r_valid <= 1'b1;
            r_inst  <= w_ld_inst;
            r_ipc   <= w_ld_pc;
            r_npc   <= w_ld_npc;
        end else if (w_ifid_kill) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign if_id_valid = r_valid;
    assign if_id_inst  = r_inst;
    assign if_id_pc    = r_ipc;
    assign if_id_npc   = r_npc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with random imem latency, stalls and redirects
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_id = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_npc;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cons = 0;
    int consumed = 0;
    int min_lat = 0, max_lat = 0, stall_pct = 0, redir_pct = 0;
    bit mem_busy = 0;
    int mem_wait = 0;
    bit was_waiting = 0;
    logic [15:0] saved_addr = 16'h0;
    bit tgt_pending = 0;
    logic [15:0] tgt = 16'h0;
    bit prev_redirect = 0;
    logic [15:0] exp_q[$];
    logic [15:0] seg_next = 16'h0;

    fetch_stage #(.ISIZE(16), .RESET_PC(16'h0)) dut (
        .clk(clk), .rst(rst), .stall_id(stall_id),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_npc(if_id_npc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected program-order stream: consecutive addresses from the latest restart point
    task automatic sb_topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(seg_next);
            seg_next = seg_next + 16'd1;
        end
    endtask

    task automatic sb_restart(input logic [15:0] start);
        exp_q.delete();
        seg_next = start;
        sb_topup();
    endtask

    // monitor: decode consumes IF/ID on an edge with valid, no stall and no flush
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            prev_redirect = 0;
        end else begin
            if (prev_redirect) check("flush_after_redirect", 32'(if_id_valid), 32'd0);
            if (if_id_valid && !stall_id && !redirect_valid) begin
                sb_topup();
                e = exp_q.pop_front();
                check("ifid_pc", 32'(if_id_pc), 32'(e));
                check("ifid_inst", 32'(if_id_inst), 32'(mem_word(e)));
                check("ifid_npc", 32'(if_id_npc), 32'(16'(e + 16'd1)));
                sb_topup();
                consumed++;
                last_cons = cyc;
            end
            prev_redirect = redirect_valid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'h0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check({tag, "_inst"}, 32'(if_id_inst), 32'h0);
        check({tag, "_pc"}, 32'(if_id_pc), 32'h0);
        check({tag, "_npc"}, 32'(if_id_npc), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_id = 1'b0;
        redirect_valid = 1'b0;
        imem_ready = 1'b0;
        mem_busy = 0;
        was_waiting = 0;
        tgt_pending = 0;
        sb_restart(16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_cons = cyc;
    endtask

    // one clock of stimulus: memory responder, protocol checks, random stall/redirect
    task automatic drive_cycle(input bit force_rd, input logic [15:0] force_pc);
        @(posedge clk);
        #1;
        cyc++;
        if (was_waiting) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_stable", 32'(imem_addr), 32'(saved_addr));
        end
        if (imem_req && !mem_busy) begin
            mem_busy = 1;
            mem_wait = $urandom_range(max_lat, min_lat);
            if (tgt_pending) check("req_at_target", 32'(imem_addr), 32'(tgt));
            tgt_pending = 0;
        end
        imem_ready = imem_req && mem_busy && (mem_wait == 0);
        if (imem_req && mem_busy) begin
            if (mem_wait == 0) mem_busy = 0;
            else mem_wait--;
        end
        was_waiting = imem_req && !imem_ready;
        saved_addr = imem_addr;
        stall_id = ($urandom_range(99, 0) < stall_pct);
        if (force_rd || ($urandom_range(99, 0) < redir_pct)) begin
            redirect_valid = 1'b1;
            if (force_rd) redirect_pc = force_pc;
            else if ($urandom_range(3, 0) == 0) redirect_pc = 16'hFFFD;
            else redirect_pc = 16'($urandom);
            sb_restart(redirect_pc);
            tgt_pending = 1;
            tgt = redirect_pc;
        end else begin
            redirect_valid = 1'b0;
        end
    endtask

    task automatic run_random(input int n);
        last_cons = cyc;
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, 16'h0);
            if (cyc - last_cons > 200) begin
                check("progress_timeout", 32'(cyc - last_cons), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int vcnt;
        int c0;
        #2;
        check_reset_outputs("reset");
        do_reset();

        // zero-wait memory, no stall: one instruction per cycle from pc 0
        min_lat = 0; max_lat = 0; stall_pct = 0; redir_pct = 0;
        for (int n = 1; n <= 6; n++) begin
            drive_cycle(1'b0, 16'h0);
            if (n >= 2) begin
                check("zw_valid", 32'(if_id_valid), 32'd1);
                check("zw_pc", 32'(if_id_pc), 32'(n - 2));
            end
        end
        vcnt = 0;
        for (int n = 0; n < 20; n++) begin
            drive_cycle(1'b0, 16'h0);
            if (if_id_valid) vcnt++;
        end
        check("zw_throughput", 32'(vcnt), 32'd20);

        // wrap-around: 16'hFFFF fetched gives npc 0 and next request at 0
        drive_cycle(1'b1, 16'hFFFE);
        c0 = 0;
        do begin
            drive_cycle(1'b0, 16'h0);
            c0++;
        end while (!(if_id_valid && if_id_pc == 16'hFFFF) && c0 < 20);
        check("wrap_seen", 32'(if_id_pc), 32'hFFFF);
        check("wrap_npc", 32'(if_id_npc), 32'h0);
        check("wrap_next_req", 32'({imem_req, imem_addr}), 32'h10000);

        // two-cycle wait memory: one word every three cycles, bubbles in between
        do_reset();
        min_lat = 2; max_lat = 2;
        repeat (10) drive_cycle(1'b0, 16'h0);
        vcnt = 0;
        for (int n = 0; n < 30; n++) begin
            drive_cycle(1'b0, 16'h0);
            if (if_id_valid) vcnt++;
        end
        check("lat2_throughput", 32'(vcnt), 32'd10);

        // asynchronous reset in the middle of a memory wait
        c0 = 0;
        do begin
            drive_cycle(1'b0, 16'h0);
            c0++;
        end while (!(imem_req && !imem_ready) && c0 < 10);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midwait_reset");
        do_reset();

        // randomized traffic
        min_lat = 0; max_lat = 3; stall_pct = 30; redir_pct = 4;
        consumed = 0;
        run_random(3000);
        check("random_progress", 32'(consumed > 300), 32'd1);

        stall_pct = 70; redir_pct = 2;
        run_random(800);

        stall_pct = 0; redir_pct = 0; min_lat = 0; max_lat = 1;
        run_random(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
